// File: rtl/ysyx_mem_arbiter_if.sv
// rtl/ysyx_mem_arbiter_if.sv - IFU/LSU request, response and shared memory port bundle
interface ysyx_mem_arbiter_if;
    logic        ifu_req_valid;
    logic [31:0] ifu_addr;
    logic        ifu_req_ready;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;

    logic        lsu_req_valid;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_req_ready;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;

    logic        mem_req_valid;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output busy
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  busy
    );
endinterface

// File: rtl/ysyx_mem_arbiter.sv
// rtl/ysyx_mem_arbiter.sv - IFU/LSU arbiter onto one memory port, LSU priority with IFU starvation guard
module ysyx_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    ysyx_mem_arbiter_if.slave bus
);
    localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state_q, state_d;
    logic          owner_lsu_q;
    logic [CW-1:0] starve_q;
    logic [31:0]   addr_q;
    logic          wen_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wmask_q;

    logic grant_lsu, grant_ifu, grant;

    // LSU normally wins; once IFU has been passed over LIMIT times it takes the next slot
    assign grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || starve_q != LIMIT);
    assign grant_ifu = bus.ifu_req_valid && !grant_lsu;
    assign grant     = (state_q == IDLE) && (grant_lsu || grant_ifu);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        bus.ifu_req_ready  = 1'b0;
        bus.lsu_req_ready  = 1'b0;
        bus.ifu_resp_valid = 1'b0;
        bus.lsu_resp_valid = 1'b0;
        bus.ifu_rdata      = 32'h0;
        bus.lsu_rdata      = 32'h0;
        bus.mem_req_valid  = 1'b0;
        // Outputs are forced low for the whole reset window, not just after the next edge
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (grant_lsu || grant_ifu) begin
                        state_d           = ISSUE;
                        bus.ifu_req_ready = grant_ifu;
                        bus.lsu_req_ready = grant_lsu;
                    end
                end
                ISSUE: begin
                    bus.mem_req_valid = 1'b1;
                    if (bus.mem_req_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        state_d = IDLE;
                        if (owner_lsu_q) begin
                            bus.lsu_resp_valid = 1'b1;
                            bus.lsu_rdata      = bus.mem_rdata;
                        end else begin
                            bus.ifu_resp_valid = 1'b1;
                            bus.ifu_rdata      = bus.mem_rdata;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_lsu_q <= 1'b0;
            starve_q    <= '0;
            addr_q      <= 32'h0;
            wen_q       <= 1'b0;
            wdata_q     <= 32'h0;
            wmask_q     <= 4'h0;
        end else if (grant) begin
            owner_lsu_q <= grant_lsu;
            if (grant_lsu) begin
                addr_q  <= bus.lsu_addr;
                wen_q   <= bus.lsu_wen;
                wdata_q <= bus.lsu_wdata;
                wmask_q <= bus.lsu_wmask;
                if (bus.ifu_req_valid && starve_q != LIMIT) begin
                    starve_q <= starve_q + CW'(1);
                end
            end else begin
                addr_q   <= bus.ifu_addr;
                wen_q    <= 1'b0;
                wdata_q  <= 32'h0;
                wmask_q  <= 4'h0;
                starve_q <= '0;
            end
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/ysyx_mem_arbiter.md
YSYX_MEM_ARBITER -- requirements
Module: ysyx_mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive LSU grants made while IFU waits before IFU is forced to win.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 ifu_req_valid  in  1  IFU fetch request pending.
REQ-005 ifu_addr  in  32  IFU fetch address.
REQ-006 ifu_req_ready  out  1  IFU request accepted this cycle.
REQ-007 ifu_resp_valid  out  1  IFU read data valid this cycle.
REQ-008 ifu_rdata  out  32  IFU read data.
REQ-009 lsu_req_valid  in  1  LSU load/store request pending.
REQ-010 lsu_addr  in  32  LSU address.
REQ-011 lsu_wen  in  1  1 = store, 0 = load.
REQ-012 lsu_wdata  in  32  store data.
REQ-013 lsu_wmask  in  4  store byte mask.
REQ-014 lsu_req_ready  out  1  LSU request accepted this cycle.
REQ-015 lsu_resp_valid  out  1  LSU load data / store ack valid this cycle.
REQ-016 lsu_rdata  out  32  LSU read data.
REQ-017 mem_req_valid  out  1  request to shared memory port.
REQ-018 mem_addr, mem_wen, mem_wdata, mem_wmask  out  32/1/32/4  registered request fields.
REQ-019 mem_req_ready  in  1  memory accepted request.
REQ-020 mem_resp_valid  in  1  memory response (reads and writes both respond).
REQ-021 mem_rdata  in  32  memory read data.
REQ-022 busy  out  1  transaction in flight (state != IDLE).

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT; one transaction outstanding at most.
REQ-024 IDLE: neither valid -> stay IDLE; any valid -> grant one requester, assert its req_ready for exactly that cycle, latch addr/wen/wdata/wmask and owner, go ISSUE.
REQ-025 IFU grants SHALL latch mem_wen=0, mem_wdata=0, mem_wmask=0.
REQ-026 Both valid in IDLE: LSU wins unless starve counter == STARVE_LIMIT, then IFU wins.
REQ-027 Starve counter SHALL increment (saturating at STARVE_LIMIT) on an LSU grant while ifu_req_valid=1, and clear on any IFU grant.
REQ-028 ISSUE: mem_req_valid=1 with latched fields; mem_req_ready=1 -> go WAIT next cycle; otherwise hold fields stable.
REQ-029 WAIT: mem_req_valid=0; mem_resp_valid=1 -> owner resp_valid=1 and owner rdata=mem_rdata combinationally that cycle, go IDLE.
REQ-030 Non-owner resp_valid SHALL be 0; ifu_rdata/lsu_rdata SHALL be 0 when their resp_valid is 0.
REQ-031 mem_resp_valid in IDLE or ISSUE SHALL be ignored (no state change, no resp_valid).
REQ-032 req_ready SHALL be 0 in ISSUE and WAIT; new grants only from IDLE, so minimum per-transaction occupancy is 3 cycles (grant, issue, response).
REQ-033 Requests dropping valid before grant SHALL be ignored; requesters hold fields until req_ready.

Reset
REQ-034 rst=1 SHALL force state IDLE, starve counter 0, owner IFU, all latched fields 0, all outputs 0, immediately and independent of clk.
REQ-035 Reset mid-transaction SHALL abandon it; a mem_resp_valid arriving after reset release SHALL be ignored per REQ-031.

Verification
REQ-036 IFU only, addr 0x80000000, mem ready and respond immediately -> ifu_req_ready cycle 0, mem_req_valid cycle 1 addr 0x80000000, ifu_resp_valid cycle 2 rdata = mem_rdata.
REQ-037 Both valid in IDLE, counter 0, LSU store addr 0x80001000 wdata 0xDEADBEEF wmask 0xF -> LSU granted, mem_wen=1 with those fields, lsu_resp_valid on ack, ifu_resp_valid stays 0.
REQ-038 IFU and LSU continuously valid -> grant order LSU x4 then IFU, repeating.
REQ-039 mem_req_ready held 0 for 5 cycles in ISSUE -> mem_req_valid and fields stable all 5 cycles, no req_ready asserted.
REQ-040 rst asserted asynchronously mid-WAIT, released, then mem_resp_valid=1 -> all outputs 0, no resp_valid, state IDLE, busy=0.
REQ-041 Spurious mem_resp_valid in IDLE with no requests -> no resp_valid, busy stays 0.
